// File: rtl/multicore_pkg.sv
// Shared op codes and FSM encoding for the multicore loader.
// Imported by the loader top and by its testbench.
package multicore_pkg;

  localparam logic [1:0] OP_LOAD_IRAM = 2'b00;
  localparam logic [1:0] OP_LOAD_DRAM = 2'b01;
  localparam logic [1:0] OP_RUN       = 2'b10;
  localparam logic [1:0] OP_READBACK  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RUN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_OUT
  } state_e;

endpackage

// File: rtl/multicore_loader_rd_pipe.sv
// DRAM read latency tracker: flags the cycle read data is due
// and captures it into the readback data register.
module loader_rd_pipe #(
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic [DW-1:0] dram_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o
);

  logic [RD_LAT-1:0] sr_q;
  logic [DW-1:0]     data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q   <= '0;
      data_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | RD_LAT'(req_i);
      if (sr_q[RD_LAT-1]) begin
        data_q <= dram_i;
      end
    end
  end

  assign vld_o  = sr_q[RD_LAT-1];
  assign data_o = data_q;

endmodule

// File: rtl/multicore_loader.sv
// Command-driven loader: streams words into per-core IRAM or
// shared DRAM, runs the cores, and reads DRAM back out.
module multicore_loader
  import multicore_pkg::*;
#(
  parameter int  N_CORES = 8,
  parameter int  AW      = 9,
  parameter int  DW      = 16,
  parameter int  RUN_W   = 24,
  parameter int  RD_LAT  = 2,
  localparam int CW      = $clog2(N_CORES) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CW-1:0]      cmd_core,
  input  logic [AW-1:0]      cmd_base,
  input  logic [AW-1:0]      cmd_len,
  input  logic [RUN_W-1:0]   cmd_cycles,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DW-1:0]      m_data,
  output logic [AW-1:0]      addr_ext,
  output logic [DW-1:0]      data_out,
  output logic [N_CORES-1:0] iram_write_ext,
  output logic               dram_write_ext,
  output logic               read_en_ext,
  input  logic [DW-1:0]      dram_in,
  output logic               start,
  output logic               start_2,
  output logic               start_3,
  output logic               start_4,
  input  logic [N_CORES-1:0] core_done,
  output logic               busy,
  output logic               err
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CW-1:0]     core_q, core_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     rem_q, rem_d;
  logic [RUN_W-1:0]  cyc_q, cyc_d;
  logic [RUN_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     data_q, data_d;
  logic              err_q, err_d;
  logic              rd_vld;
  logic              is_iram;
  logic              bad_core;
  logic              zero_len;

  loader_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .req_i  (read_en_ext),
    .dram_i (dram_in),
    .vld_o  (rd_vld),
    .data_o (m_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD_IRAM;
      core_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      core_q  <= core_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign is_iram  = (op_q == OP_LOAD_IRAM);
  assign bad_core = (cmd_core >= CW'(N_CORES));
  assign zero_len = (cmd_len == '0);

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    core_d         = core_q;
    addr_d         = addr_q;
    rem_d          = rem_q;
    cyc_d          = cyc_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    err_d          = err_q;
    cmd_ready      = 1'b0;
    s_ready        = 1'b0;
    m_valid        = 1'b0;
    read_en_ext    = 1'b0;
    dram_write_ext = 1'b0;
    iram_write_ext = '0;
    start          = 1'b0;
    start_2        = 1'b0;
    start_3        = 1'b0;
    start_4        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          err_d = (cmd_op == OP_LOAD_IRAM) && bad_core;
          // a rejected IRAM load leaves every latched field alone
          if (!err_d) begin
            op_d   = cmd_op;
            core_d = cmd_core;
            addr_d = cmd_base;
            rem_d  = cmd_len;
            cyc_d  = cmd_cycles;
            cnt_d  = '0;
            if (cmd_op == OP_RUN) begin
              state_d = ST_RUN;
            end else if (zero_len) begin
              state_d = ST_IDLE;
            end else if (cmd_op == OP_READBACK) begin
              state_d = ST_RD_REQ;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        start_2 = is_iram;
        start_3 = !is_iram;
        if (s_valid) begin
          data_d  = s_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        start_2 = is_iram;
        start_3 = !is_iram;
        if (is_iram) begin
          iram_write_ext = N_CORES'(1) << core_q;
        end else begin
          dram_write_ext = 1'b1;
        end
        addr_d  = addr_q + AW'(1);
        rem_d   = rem_q - AW'(1);
        state_d = (rem_q == AW'(1)) ? ST_IDLE : ST_LOAD;
      end
      ST_RUN: begin
        start = 1'b1;
        cnt_d = cnt_q + RUN_W'(1);
        if ((&core_done) || (cyc_q != '0 && cnt_d == cyc_q)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        start_4     = 1'b1;
        read_en_ext = 1'b1;
        state_d     = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        start_4 = 1'b1;
        if (rd_vld) begin
          state_d = ST_RD_OUT;
        end
      end
      ST_RD_OUT: begin
        start_4 = 1'b1;
        m_valid = 1'b1;
        if (m_ready) begin
          addr_d  = addr_q + AW'(1);
          rem_d   = rem_q - AW'(1);
          state_d = (rem_q == AW'(1)) ? ST_IDLE : ST_RD_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign addr_ext = addr_q;
  assign data_out = data_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

endmodule

// File: doc/multicore_loader.md
MULTICORE_LOADER -- requirements
Module: multicore_loader

Interface
REQ-001 Parameter N_CORES, default 8: number of cores with private IRAM write enables.
REQ-002 Parameter AW, default 9: IRAM/DRAM address width.
REQ-003 Parameter DW, default 16: instruction/data word width.
REQ-004 Parameter RUN_W, default 24: run-cycle limit width.
REQ-005 Parameter RD_LAT, default 2: DRAM read latency in clocks, 1..4.
REQ-006 clock  in  1  system clock; all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 cmd_valid / cmd_ready  in / out  1  command handshake; transfer when both are high.
REQ-009 cmd_op  in  2  00 LOAD_IRAM, 01 LOAD_DRAM, 10 RUN, 11 READBACK.
REQ-010 cmd_core  in  $clog2(N_CORES)+1  target core for LOAD_IRAM.
REQ-011 cmd_base, cmd_len  in  AW each  start address and word count.
REQ-012 cmd_cycles  in  RUN_W  RUN limit; 0 = no limit.
REQ-013 s_valid / s_ready / s_data  in / out / in  1/1/DW  load word stream.
REQ-014 m_valid / m_ready / m_data  out / in / out  1/1/DW  readback word stream.
REQ-015 addr_ext  out  AW  shared memory address.
REQ-016 data_out  out  DW  write data driven to both IRAM and DRAM.
REQ-017 iram_write_ext  out  N_CORES  one-hot IRAM write strobe.
REQ-018 dram_write_ext / read_en_ext  out  1 each  DRAM write and read strobes.
REQ-019 dram_in  in  DW  DRAM read data.
REQ-020 start, start_2, start_3, start_4  out  1 each  run, IRAM-load, DRAM-load and readback mode flags.
REQ-021 core_done  in  N_CORES  per-core completion.
REQ-022 busy, err  out  1 each  command active; sticky bad-command flag.

Function
REQ-023 FSM states: IDLE, LOAD, WRITE, RUN, RD_REQ, RD_WAIT, RD_OUT. cmd_ready SHALL be high only in IDLE.
REQ-024 Accepted command SHALL latch op, core, base, len and cycles; busy SHALL be high from the next cycle until return to IDLE.
REQ-025 LOAD: s_ready=1. Handshake SHALL register addr_ext and data_out; next cycle (WRITE) SHALL pulse exactly one strobe for one clock (iram_write_ext[core] or dram_write_ext) with addr/data stable; address SHALL then increment modulo 2^AW.
REQ-026 Minimum throughput SHALL be one word per 2 clocks; s_ready SHALL be low in WRITE.
REQ-027 cmd_len=0 for load or readback SHALL return to IDLE in 1 cycle with no strobes.
REQ-028 LOAD_IRAM with cmd_core>=N_CORES SHALL drop the command, set err, and issue no strobes; err SHALL clear on the next accepted valid command.
REQ-029 start_2 SHALL be high throughout an IRAM load, start_3 throughout a DRAM load, start_4 throughout readback, start throughout RUN. At most one of the four SHALL be high.
REQ-030 RUN SHALL exit to IDLE when core_done is all-ones or the cycle counter reaches cmd_cycles (nonzero). If both occur in the same cycle, done wins with no difference in outputs.
REQ-031 READBACK: RD_REQ drives read_en_ext=1 for one clock; RD_WAIT lasts RD_LAT clocks; dram_in SHALL be captured into m_data. RD_OUT holds m_valid=1 and stable m_data until m_ready; the address then increments, and the FSM returns to RD_REQ or to IDLE after len words.
REQ-032 cmd_valid arriving while busy SHALL be ignored, with no latching.

Reset
REQ-033 reset_n low SHALL force IDLE, with all strobes, mode flags, s_ready, m_valid, busy and err at 0. addr_ext, data_out and m_data SHALL be 0; cmd_ready SHALL be 1 after release.
REQ-034 Reset mid-WRITE SHALL drop the strobe in the same instant, because assertion is asynchronous.

Structure
REQ-035 Shared package multicore_pkg SHALL hold the op-code localparams and the FSM state encoding.
REQ-036 One sub-module, loader_rd_pipe, SHALL implement the RD_LAT delay and capture.

Verification
REQ-037 LOAD_IRAM core 3, base 1, len 4, data 10..13: iram_write_ext=8'b0000_1000 SHALL pulse 4 times at addr 1..4 with matching data_out; start_2=1 during the load.
REQ-038 LOAD_DRAM base 510, len 4: writes SHALL go to 510, 511, 0, 1 (wrap); s_valid gaps SHALL cause no extra strobes.
REQ-039 LOAD_IRAM with cmd_core=9: err=1, zero strobes; the next valid command SHALL clear err.
REQ-040 RUN cycles=100: core_done=all-ones at cycle 40 SHALL exit at 40. A second RUN with core_done=0 SHALL exit after 100; cycles=0 SHALL never time out.
REQ-041 READBACK base 5, len 3, RD_LAT=2, m_ready low 5 cycles: m_data SHALL be held stable and equal to DRAM[5..7] in order; exactly 3 read_en_ext pulses.
REQ-042 reset_n pulsed low mid-LOAD: all outputs SHALL be at reset values immediately; cmd_ready=1 after release.
